// File: rtl/alu_req_arbiter_if.sv
// Request/response bundle between NUM_REQ issue units and the shared-alu arbiter.
// Pure wiring: no storage, no added latency.
// Backpressure: req_ready per requester on the request side, rsp_ready on the response side.
interface alu_req_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*4-1:0]     req_op;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_zero;
  logic                     rsp_err;

  // Requester / response-consumer side.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin share of one registered alu among NUM_REQ requesters; ALU_ARB_OPCHK_EN blocks ops > 6.
// Latency: grant in cycle N, tagged response valid in cycle N+2; peak one op every 2 cycles.
// Backpressure: response held while rsp_ready low; no new grant until the pending response retires.
module alu_req_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_req_arbiter_if.slave     bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_ctrl,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_zero,
  output logic                 busy
);
  localparam int IDW = $clog2(NUM_REQ);
  // One extra bit so rr_ptr + offset can exceed NUM_REQ-1 before the wrap.
  localparam int PW  = IDW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   rsp_id_q;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   nxt_ptr;
  logic [PW-1:0]    cand;
  logic             gnt_found;
  logic             grant_win;
  logic             grant;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_op;
`ifdef ALU_ARB_OPCHK_EN
  logic             err_q;
`endif

  // Round-robin search: first valid requester starting at rr_ptr, wrapping mod NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PW'(rr_ptr) + PW'(k);
      if (cand >= PW'(NUM_REQ)) begin
        cand = cand - PW'(NUM_REQ);
      end
      if (!gnt_found && bus.req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  // A grant is only possible when the alu is free or its result is retiring this cycle.
  assign grant_win = !rst && ((state == IDLE) || ((state == RESP) && bus.rsp_ready));
  assign grant     = grant_win && gnt_found;

  assign bus.req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;

  assign sel_a   = bus.req_a[gnt_idx*WIDTH +: WIDTH];
  assign sel_b   = bus.req_b[gnt_idx*WIDTH +: WIDTH];
  assign sel_op  = bus.req_op[gnt_idx*4 +: 4];
  assign nxt_ptr = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Sequencer, pointer and issue registers; alu inputs only change on a grant so its result stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      rsp_id_q <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= 4'd0;
`ifdef ALU_ARB_OPCHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:    if (grant) state <= ISSUE;
        ISSUE:   state <= RESP;
        RESP:    if (bus.rsp_ready) state <= grant ? ISSUE : IDLE;
        default: state <= IDLE;
      endcase

      if (grant) begin
        rr_ptr   <= nxt_ptr;
        rsp_id_q <= gnt_idx;
`ifdef ALU_ARB_OPCHK_EN
        // Illegal codes never reach the alu; it sees a harmless zero add instead.
        if (sel_op > 4'd6) begin
          alu_a    <= '0;
          alu_b    <= '0;
          alu_ctrl <= 4'd0;
          err_q    <= 1'b1;
        end else begin
          alu_a    <= sel_a;
          alu_b    <= sel_b;
          alu_ctrl <= sel_op;
          err_q    <= 1'b0;
        end
`else
        alu_a    <= sel_a;
        alu_b    <= sel_b;
        alu_ctrl <= sel_op;
`endif
      end
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state != IDLE);

`ifdef ALU_ARB_OPCHK_EN
  assign bus.rsp_result = err_q ? '0 : alu_result;
  assign bus.rsp_zero   = err_q | alu_zero;
  assign bus.rsp_err    = err_q;
`else
  assign bus.rsp_result = alu_result;
  assign bus.rsp_zero   = alu_zero;
  assign bus.rsp_err    = 1'b0;
`endif
endmodule
